// File: rtl/be_field_extractor.sv
// be_field_extractor: pulls one big-endian field out of a byte stream and
// returns it in host order, zero-extended to the stream width.
module be_field_extractor #(
  parameter int unsigned OFFSET_W = 16,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OFFSET_W-1:0]   cfg_offset,
  input  logic [3:0]            cfg_size,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [DATA_W/8-1:0]   s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_W-1:0]     m_field,
  output logic                  m_err,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int unsigned LANES = DATA_W / 8;
  // Counter needs headroom past the largest offset plus one beat.
  localparam int unsigned CNT_W = OFFSET_W + 2;

  if (DATA_W != 64) begin : g_bad_width
    $fatal(1, "be_field_extractor: DATA_W must be 64");
  end

  typedef enum logic [1:0] {SOF, ACCUM, DRAIN} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [OFFSET_W-1:0] off_q;
  logic [3:0]          sz_q;
  logic [DATA_W-1:0]   acc;

  logic                beat;
  logic [OFFSET_W-1:0] off_c;
  logic [3:0]          sz_c;
  logic                legal_c;
  logic [CNT_W-1:0]    base_c;
  logic [CNT_W-1:0]    fstart_c;
  logic [CNT_W-1:0]    fend_c;
  logic [CNT_W-1:0]    idx_c;
  logic [DATA_W-1:0]   acc_nxt_c;
  logic                done_c;
  logic [3:0]          nbytes_c;

  assign s_tready = !(m_valid && !m_ready);
  assign beat     = s_tvalid && s_tready;

  // Lane datapath: gather in-range bytes MSB-first and detect field completion.
  always_comb begin
    off_c     = (state == SOF) ? cfg_offset : off_q;
    sz_c      = (state == SOF) ? cfg_size : sz_q;
    legal_c   = (sz_c == 4'd2) || (sz_c == 4'd4) || (sz_c == 4'd8);
    base_c    = (state == SOF) ? '0 : cnt;
    acc_nxt_c = (state == SOF) ? '0 : acc;
    fstart_c  = CNT_W'(off_c);
    fend_c    = fstart_c + CNT_W'(sz_c);
    idx_c     = '0;
    done_c    = 1'b0;
    nbytes_c  = '0;
    for (int i = 0; i < LANES; i++) begin
      idx_c = base_c + CNT_W'(i);
      if (s_tkeep[i]) begin
        nbytes_c = nbytes_c + 4'd1;
        if ((idx_c >= fstart_c) && (idx_c < fend_c)) begin
          acc_nxt_c = {acc_nxt_c[DATA_W-9:0], s_tdata[8*i +: 8]};
          if (idx_c == fend_c - CNT_W'(1)) done_c = 1'b1;
        end
      end
    end
  end

  // Message state machine, byte counter and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SOF;
      cnt     <= '0;
      off_q   <= '0;
      sz_q    <= '0;
      acc     <= '0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_field <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (beat) begin
        case (state)
          SOF, ACCUM: begin
            if (state == SOF) begin
              off_q <= cfg_offset;
              sz_q  <= cfg_size;
            end
            cnt <= s_tlast ? '0 : base_c + CNT_W'(nbytes_c);
            acc <= '0;
            if ((state == SOF) && !legal_c) begin
              m_valid <= 1'b1;
              m_err   <= 1'b1;
              m_field <= '0;
              state   <= s_tlast ? SOF : DRAIN;
            end else if (done_c) begin
              m_valid <= 1'b1;
              m_err   <= 1'b0;
              m_field <= acc_nxt_c;
              state   <= s_tlast ? SOF : DRAIN;
            end else if (s_tlast) begin
              m_valid <= 1'b1;
              m_err   <= 1'b1;
              m_field <= '0;
              state   <= SOF;
            end else begin
              acc   <= acc_nxt_c;
              state <= ACCUM;
            end
          end
          DRAIN: begin
            cnt <= '0;
            if (s_tlast) state <= SOF;
          end
          default: state <= SOF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_be_field_extractor.sv
// Directed bench for be_field_extractor with a result scoreboard.
module tb_be_field_extractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_offset;
  logic [3:0]  cfg_size;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_field;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;

  typedef struct packed {
    logic [63:0] field;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  be_field_extractor #(.OFFSET_W(16), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_offset(cfg_offset), .cfg_size(cfg_size),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_field(m_field), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [63:0] f, input logic e);
    exp_t x;
    x.field = f;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 200);
    if (!s_tready) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  // Scoreboard: compare each handed-off result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_field", m_field, e.field);
        check("sb_err", {63'd0, m_err}, {63'd0, e.err});
      end
    end
  end

  // Stimulus legality: tkeep full on non-last beats and contiguous from lane 0.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && s_tvalid === 1'b1) begin
      logic [7:0] kp1;
      kp1 = s_tkeep + 8'd1;
      total++;
      assert ((s_tlast || s_tkeep == 8'hFF) && ((s_tkeep & kp1) == 8'h00)) else begin
        bad++;
        $error("FAIL tkeep_legal observed=%h expected=contiguous", s_tkeep);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cfg_offset = '0;
    cfg_size   = 4'd0;
    s_tdata    = '0;
    s_tkeep    = 8'h00;
    s_tlast    = 1'b0;
    s_tvalid   = 1'b0;
    m_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_err", {63'd0, m_err}, 64'd0);
    check("rst_m_field", m_field, 64'd0);
    check("rst_s_tready", {63'd0, s_tready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Field inside a single beat
    cfg_offset = 16'd3; cfg_size = 4'd4;
    push_exp(64'h0000_0000_0304_0506, 1'b0);
    send(64'h0706050403020100, 8'hFF, 1'b1);
    check("t1_latency_valid", {63'd0, m_valid}, 64'd1);
    check("t1_field", m_field, 64'h0000_0000_0304_0506);

    // Field spanning two beats
    cfg_offset = 16'd6; cfg_size = 4'd4;
    push_exp(64'h0000_0000_0607_0809, 1'b0);
    send(64'h0706050403020100, 8'hFF, 1'b0);
    check("t2_no_early_valid", {63'd0, m_valid}, 64'd0);
    cfg_offset = 16'd0; cfg_size = 4'd2;
    send(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1);
    check("t2_valid", {63'd0, m_valid}, 64'd1);
    check("t2_field", m_field, 64'h0000_0000_0607_0809);

    // 64-bit field at offset 0, trailing beats drained
    cfg_offset = 16'd0; cfg_size = 4'd8;
    push_exp(64'h8877665544332211, 1'b0);
    send(64'h1122334455667788, 8'hFF, 1'b0);
    check("t3_valid", {63'd0, m_valid}, 64'd1);
    check("t3_field", m_field, 64'h8877665544332211);
    send(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);
    send(64'h0000000000123456, 8'h07, 1'b1);

    // Truncated message
    cfg_offset = 16'd12; cfg_size = 4'd8;
    push_exp(64'd0, 1'b1);
    send(64'h0706050403020100, 8'hFF, 1'b1);
    check("t4_err", {63'd0, m_err}, 64'd1);
    check("t4_field", m_field, 64'd0);

    // Illegal size, rest of the message drained
    cfg_offset = 16'd0; cfg_size = 4'd3;
    push_exp(64'd0, 1'b1);
    send(64'h0706050403020100, 8'hFF, 1'b0);
    check("t5_err", {63'd0, m_err}, 64'd1);
    check("t5_valid", {63'd0, m_valid}, 64'd1);
    send(64'h1111111111111111, 8'hFF, 1'b0);
    send(64'h2222222222222222, 8'h0F, 1'b1);

    // Backpressure on the result holds off the next message
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    cfg_offset = 16'd1; cfg_size = 4'd2;
    push_exp(64'h0000_0000_0000_A1A2, 1'b0);
    send(64'hA7A6A5A4A3A2A1A0, 8'hFF, 1'b1);
    cfg_offset = 16'd4; cfg_size = 4'd2;
    s_tdata = 64'hB7B6B5B4B3B2B1B0; s_tkeep = 8'hFF; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6_stall_tready", {63'd0, s_tready}, 64'd0);
      check("t6_hold_field", m_field, 64'h0000_0000_0000_A1A2);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    push_exp(64'h0000_0000_0000_B4B5, 1'b0);
    send(64'hB7B6B5B4B3B2B1B0, 8'hFF, 1'b1);
    check("t6_second_field", m_field, 64'h0000_0000_0000_B4B5);

    // Reset in the middle of a spanning message
    cfg_offset = 16'd6; cfg_size = 4'd4;
    send(64'h0706050403020100, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t7_rst_valid", {63'd0, m_valid}, 64'd0);
    check("t7_rst_err", {63'd0, m_err}, 64'd0);
    check("t7_rst_field", m_field, 64'd0);
    check("t7_rst_tready", {63'd0, s_tready}, 64'd1);
    rst_n = 1'b1;
    cfg_offset = 16'd6; cfg_size = 4'd2;
    push_exp(64'h0000_0000_0000_0E0F, 1'b0);
    send(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1);
    check("t7_field", m_field, 64'h0000_0000_0000_0E0F);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("final_idle", {63'd0, m_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
